// File: rtl/lfsr_prbs_gen.sv
// Configurable LFSR PRBS generator with Fibonacci/Galois stepping, seed loading,
// zero-state recovery and period measurement against a reference seed.
module lfsr_prbs_gen #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] TAPS  = 24'hE10000,
  parameter logic [WIDTH-1:0] SEED  = 24'h9F9000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             bit_out,
  output logic             period_tick,
  output logic [WIDTH-1:0] step_count,
  output logic [WIDTH-1:0] period_len,
  output logic             seed_err
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] len_q;
  logic             tick_q;
  logic             err_q;

  logic             fib_tap;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_val;
  logic             load_zero;
  logic             state_zero;
  logic             wrap;

  always_comb begin
    fib_tap    = ^(state_q & TAPS);
    fib_next   = {state_q[WIDTH-2:0], fib_tap};
    // Galois: rotate left, then fold the outgoing MSB into every tapped position.
    gal_next   = {state_q[WIDTH-2:0], state_q[WIDTH-1]}
               ^ ({TAPS[WIDTH-2:0], 1'b0} & {WIDTH{state_q[WIDTH-1]}});
    step_next  = mode ? gal_next : fib_next;
    load_zero  = (seed_in == '0);
    load_val   = load_zero ? SEED : seed_in;
    state_zero = (state_q == '0);
    wrap       = (step_next == ref_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
      ref_q   <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      if (load) begin
        state_q <= load_val;
        ref_q   <= load_val;
        cnt_q   <= '0;
        err_q   <= load_zero;
      end else if (en) begin
        if (state_zero) begin
          // All-zero is a lock-up state for XOR feedback; recover to SEED.
          state_q <= SEED;
          cnt_q   <= '0;
          err_q   <= 1'b1;
        end else begin
          state_q <= step_next;
          if (wrap) begin
            tick_q <= 1'b1;
            len_q  <= cnt_q + WIDTH'(1);
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
      end
    end
  end

  assign lfsr_out    = state_q;
  assign bit_out     = state_q[WIDTH-1];
  assign period_tick = tick_q;
  assign step_count  = cnt_q;
  assign period_len  = len_q;
  assign seed_err    = err_q;

endmodule
